regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised integer register file for the pipelined core: multiple async read ports, multiple sync write ports, optional write-to-read bypass and a per-register busy scoreboard for RAW/WAW hazard tracking. Decode reserves a destination register; writeback clears the reservation when it writes. Reset loads the stack pointer into a configurable register index.

Parameters:
ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
DATA_WIDTH, 64, register width in bits
NUM_READ, 2, number of async read ports (1..4)
NUM_WRITE, 2, number of write ports (1..2)
SP_INDEX, 2, register loaded with stackptr on reset
BYPASS, 1, 1 = read ports see same-cycle write data; 0 = reads see stored value only

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
stackptr  in  DATA_WIDTH  value loaded into register SP_INDEX on reset
rd_addr  in  NUM_READ*ADDR_WIDTH  read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  NUM_READ*DATA_WIDTH  read data, same packing
rd_busy  out  NUM_READ  1 = addressed register has a pending reservation (post-bypass)
rsv_valid  in  1  decode requests reservation of rsv_addr
rsv_addr  in  ADDR_WIDTH  destination register to reserve
rsv_ready  out  1  reservation accepted this cycle (rsv_valid && rsv_ready = handshake)
wr_en  in  NUM_WRITE  per-port write enable
wr_addr  in  NUM_WRITE*ADDR_WIDTH  per-port write address
wr_data  in  NUM_WRITE*DATA_WIDTH  per-port write data
wr_complete  out  NUM_WRITE  registered; high one cycle after an accepted write
busy_vec  out  NUM_REGS  current scoreboard state, bit 0 always 0

Behaviour:
- Reset (sync, has priority over all inputs, including mid-reservation): all registers 0 except SP_INDEX = stackptr; busy_vec = 0; wr_complete = 0. Reservations outstanding at reset are discarded.
- Register 0: reads always return 0, rd_busy 0; writes to 0 ignored (wr_complete still asserts); reservation of 0 always accepted, sets nothing.
- Writes: on posedge, for each port with wr_en, reg[wr_addr] <= wr_data. Same address on both ports: higher port index wins. wr_complete[p] <= wr_en[p] the following cycle, for any address.
- Write clears busy[wr_addr] on the same edge.
- Reservation: rsv_ready = !busy[rsv_addr] || rsv_addr==0 || (write this cycle to rsv_addr) — WAW stall otherwise. On handshake busy[rsv_addr] <= 1.
- Same cycle reserve + write to same reg: busy ends 1 (new reservation wins over clear); data still written.
- Reads (combinational, zero latency): BYPASS=1 and some wr_en with matching nonzero addr -> rd_data = highest-index matching wr_data, rd_busy = 0; otherwise stored value and busy bit. BYPASS=0 -> stored value and stored busy bit.
- rsv_valid without rsv_ready: no state change; decode holds request.
- No arithmetic; data stored unmodified, signedness irrelevant to storage.

Decomposition:
- Package regfile_pkg: ADDR_WIDTH/DATA_WIDTH defaults, SP_INDEX default, ZERO_REG constant, reg_idx_t and reg_data_t typedefs.
- One sub-module natural: regfile_busy_table (busy_vec, reservation handshake, clear logic); data array and bypass mux stay in the top.

Test Plan:
- Reset with stackptr=0x8000_0000 -> reg2 reads 0x8000_0000, every other reg reads 0, busy_vec=0, wr_complete=0.
- Write port0 reg5=0x1234, same cycle read reg5 with BYPASS=1 -> rd_data=0x1234; next cycle stored 0x1234, wr_complete[0]=1 for exactly one cycle.
- Both ports write reg7 (0xAAAA on p0, 0xBBBB on p1) -> reg7=0xBBBB, bypass read returns 0xBBBB, both wr_complete bits high next cycle.
- Reserve reg9 -> busy[9]=1, rd_busy=1 on a read of 9; second reserve of 9 -> rsv_ready=0; write reg9=0x55 -> busy cleared, same-cycle re-reserve accepted, busy[9] stays 1.
- Write reg0=0xFFFF and reserve reg0 -> reg0 reads 0, rsv_ready=1, busy_vec[0]=0, wr_complete asserted.
- Reserve reg3 and reg4, assert reset mid-sequence -> busy_vec=0, reg3/reg4=0, reservations lost, rsv_ready=1 next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the integer register file and its busy scoreboard.
package regfile_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int SP_INDEX_DEF   = 2;
    localparam int ZERO_REG       = 0;

    typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_busy_table.sv
// Per-register busy scoreboard: decode reserves destinations, writeback clears them.
module regfile_busy_table
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_WRITE  = 2,
    localparam int NUM_REGS  = 2 ** ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rsv_valid,
    input  logic [ADDR_WIDTH-1:0]         rsv_addr,
    output logic                          rsv_ready,
    input  logic [NUM_WRITE-1:0]          wr_en,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
    output logic [NUM_REGS-1:0]           busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;
    logic                write_hit;
    logic                rsv_is_zero;

    assign rsv_is_zero = (rsv_addr == ADDR_WIDTH'(ZERO_REG));

    // A write landing on the requested register this cycle frees it, so the
    // reservation need not stall behind it.
    always_comb begin
        write_hit = 1'b0;
        for (int p = 0; p < NUM_WRITE; p++) begin
            if (wr_en[p] && (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == rsv_addr)) begin
                write_hit = 1'b1;
            end
        end
        rsv_ready = !busy_q[rsv_addr] || rsv_is_zero || write_hit;
    end

    always_comb begin
        busy_next = busy_q;
        for (int p = 0; p < NUM_WRITE; p++) begin
            if (wr_en[p]) begin
                busy_next[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        // NOTE: the set comes after the clears so a same-cycle reservation wins.
        if (rsv_valid && rsv_ready && !rsv_is_zero) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with optional write-to-read bypass and
// a busy scoreboard for RAW/WAW hazard tracking.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int SP_INDEX   = SP_INDEX_DEF,
    parameter int BYPASS     = 1,
    localparam int NUM_REGS  = 2 ** ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           stackptr,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_READ-1:0]             rd_busy,
    input  logic                            rsv_valid,
    input  logic [ADDR_WIDTH-1:0]           rsv_addr,
    output logic                            rsv_ready,
    input  logic [NUM_WRITE-1:0]            wr_en,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_WRITE-1:0]            wr_complete,
    output logic [NUM_REGS-1:0]             busy_vec
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    regfile_busy_table #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WRITE  (NUM_WRITE)
    ) u_busy_table (
        .clk       (clk),
        .reset     (reset),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .busy_vec  (busy_vec)
    );

    // NOTE: the array is reset because software relies on zeroed registers and a
    // valid stack pointer; this rules out mapping it onto a RAM macro.
    // Ports are scanned in ascending order so the higher index wins on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= (r == SP_INDEX) ? stackptr : '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                for (int p = 0; p < NUM_WRITE; p++) begin
                    if (wr_en[p] && (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
                        regs[r] <= wr_data[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_complete <= '0;
        end else begin
            wr_complete <= wr_en;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
            rd_busy[i] = busy_vec[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WRITE; p++) begin
                    if (wr_en[p] &&
                        (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
                        rd_busy[i] = 1'b0;
                    end
                end
            end
            // Register 0 is hardwired, whatever the array or bypass path holds.
            if (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(ZERO_REG)) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                rd_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with default parameters (BYPASS=1).
module tb_regfile_scoreboard;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int NREGS = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [DW-1:0]     stackptr;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic              rsv_ready;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NW-1:0]     wr_complete;
    logic [NREGS-1:0]  busy_vec;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .stackptr    (stackptr),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .rsv_valid   (rsv_valid),
        .rsv_addr    (rsv_addr),
        .rsv_ready   (rsv_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_complete (wr_complete),
        .busy_vec    (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p] = en;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        rd_addr[i*AW +: AW] = a;
    endtask

    initial begin
        reset     = 1'b1;
        stackptr  = 64'h8000_0000;
        rd_addr   = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state: only the stack pointer register is nonzero.
        for (int r = 0; r < NREGS; r++) begin
            set_rd(0, AW'(r));
            #1;
            check($sformatf("reset_reg%0d", r), rd_data[DW-1:0], (r == 2) ? 64'h8000_0000 : 64'h0);
        end
        check("reset_busy_vec", 64'(busy_vec), 64'h0);
        check("reset_wr_complete", 64'(wr_complete), 64'h0);

        // Single write with same-cycle bypass read.
        set_wr(0, 1'b1, 5'd5, 64'h1234);
        set_rd(0, 5'd5);
        #1;
        check("bypass_reg5", rd_data[DW-1:0], 64'h1234);
        check("bypass_reg5_busy", 64'(rd_busy[0]), 64'h0);
        tick();
        set_wr(0, 1'b0, 5'd0, 64'h0);
        #1;
        check("stored_reg5", rd_data[DW-1:0], 64'h1234);
        check("wr_complete_p0", 64'(wr_complete), 64'h1);
        tick();
        check("wr_complete_one_cycle", 64'(wr_complete), 64'h0);

        // Dual write to the same register: port 1 wins.
        set_wr(0, 1'b1, 5'd7, 64'hAAAA);
        set_wr(1, 1'b1, 5'd7, 64'hBBBB);
        set_rd(1, 5'd7);
        #1;
        check("bypass_reg7_collision", rd_data[2*DW-1:DW], 64'hBBBB);
        tick();
        set_wr(0, 1'b0, 5'd0, 64'h0);
        set_wr(1, 1'b0, 5'd0, 64'h0);
        #1;
        check("stored_reg7_collision", rd_data[2*DW-1:DW], 64'hBBBB);
        check("wr_complete_both", 64'(wr_complete), 64'h3);

        // Reservation and WAW stall on register 9.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        set_rd(0, 5'd9);
        #1;
        check("rsv9_ready_first", 64'(rsv_ready), 64'h1);
        tick();
        check("busy9_set", 64'(busy_vec), 64'h200);
        check("rd_busy9", 64'(rd_busy[0]), 64'h1);
        check("rsv9_waw_stall", 64'(rsv_ready), 64'h0);
        tick();
        check("busy9_held_on_stall", 64'(busy_vec), 64'h200);

        // Writeback to 9 plus same-cycle re-reservation: accepted, busy stays set.
        set_wr(0, 1'b1, 5'd9, 64'h55);
        #1;
        check("rsv9_ready_on_write", 64'(rsv_ready), 64'h1);
        check("bypass_reg9", rd_data[DW-1:0], 64'h55);
        check("bypass_reg9_busy", 64'(rd_busy[0]), 64'h0);
        tick();
        set_wr(0, 1'b0, 5'd0, 64'h0);
        rsv_valid = 1'b0;
        #1;
        check("busy9_rereserved", 64'(busy_vec), 64'h200);
        check("stored_reg9", rd_data[DW-1:0], 64'h55);
        check("rd_busy9_rereserved", 64'(rd_busy[0]), 64'h1);

        // Plain writeback clears the reservation.
        set_wr(1, 1'b1, 5'd9, 64'h66);
        tick();
        set_wr(1, 1'b0, 5'd0, 64'h0);
        #1;
        check("busy9_cleared", 64'(busy_vec), 64'h0);
        check("stored_reg9_second", rd_data[DW-1:0], 64'h66);

        // Register 0: writes ignored, reservation always accepted and sets nothing.
        set_wr(0, 1'b1, 5'd0, 64'hFFFF);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd0;
        set_rd(0, 5'd0);
        #1;
        check("reg0_bypass_zero", rd_data[DW-1:0], 64'h0);
        check("rsv0_ready", 64'(rsv_ready), 64'h1);
        tick();
        set_wr(0, 1'b0, 5'd0, 64'h0);
        rsv_valid = 1'b0;
        #1;
        check("reg0_stored_zero", rd_data[DW-1:0], 64'h0);
        check("reg0_busy_vec", 64'(busy_vec), 64'h0);
        check("reg0_wr_complete", 64'(wr_complete), 64'h1);

        // Reservations of 3 and 4 lost across a mid-sequence reset.
        set_wr(0, 1'b1, 5'd3, 64'h33);
        set_wr(1, 1'b1, 5'd4, 64'h44);
        tick();
        set_wr(0, 1'b0, 5'd0, 64'h0);
        set_wr(1, 1'b0, 5'd0, 64'h0);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd3;
        tick();
        rsv_addr  = 5'd4;
        tick();
        check("busy_3_4", 64'(busy_vec), 64'h18);
        rsv_addr  = 5'd5;
        stackptr  = 64'h1234_5678_9ABC_DEF0;
        set_wr(0, 1'b1, 5'd3, 64'h77);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsv_valid = 1'b0;
        set_wr(0, 1'b0, 5'd0, 64'h0);
        set_rd(0, 5'd3);
        set_rd(1, 5'd4);
        #1;
        check("post_reset_busy_vec", 64'(busy_vec), 64'h0);
        check("post_reset_reg3", rd_data[DW-1:0], 64'h0);
        check("post_reset_reg4", rd_data[2*DW-1:DW], 64'h0);
        check("post_reset_wr_complete", 64'(wr_complete), 64'h0);
        set_rd(0, 5'd2);
        #1;
        check("post_reset_sp", rd_data[DW-1:0], 64'h1234_5678_9ABC_DEF0);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd3;
        #1;
        check("post_reset_rsv3_ready", 64'(rsv_ready), 64'h1);
        tick();
        rsv_valid = 1'b0;
        #1;
        check("post_reset_rsv3_taken", 64'(busy_vec), 64'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
